// File: rtl/kanji_mem_responder_pkg.sv
// Shared types and constants for the Kanji/Hangul font-ROM memory responder.
package kanji_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } resp_state_t;

   localparam logic [7:0] KANJI_FILL_BYTE = 8'hFF;

   // Byte lane select inside a 16-bit SDRAM word: low byte is the even address.
   function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/kanji_mem_responder_hit_buf.sv
// One-word hit buffer: holds the last fetched SDRAM word and reports a hit
// when the requested word address matches.
module resp_hit_buf
   import kanji_mem_responder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [25:0] load_addr,
   input  logic [15:0] load_word,
   input  logic        invalidate,
   input  logic [25:0] cmp_addr,
   input  logic        cmp_byte_hi,
   output logic        hit,
   output logic [7:0]  hit_byte
);

   logic        buf_valid_q, buf_valid_d;
   logic [25:0] buf_addr_q,  buf_addr_d;
   logic [15:0] buf_word_q,  buf_word_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_word_d  = buf_word_q;
      if (load) begin
         buf_valid_d = 1'b1;
         buf_addr_d  = load_addr;
         buf_word_d  = load_word;
      end
      // Invalidate wins over a coincident load: the word is kept but never matches.
      if (invalidate) begin
         buf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_word_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_word_q  <= buf_word_d;
      end
   end

   assign hit      = buf_valid_q && (buf_addr_q == cmp_addr);
   assign hit_byte = sel_byte(buf_word_q, cmp_byte_hi);

endmodule

// File: rtl/kanji_mem_responder.sv
// Services font-ROM byte reads from a 16-bit SDRAM port, stalling the CPU
// via wait_n during a fetch, with a one-word hit buffer and a fetch timeout.
module kanji_mem_responder
   import kanji_mem_responder_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ram_cs,
   input  logic [26:0] ram_addr,
   input  logic        invalidate,
   output logic        mem_req,
   output logic [25:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_data,
   output logic [7:0]  data_out,
   output logic        wait_n,
   output logic        timeout_err
);

   localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

   resp_state_t state_q, state_d;
   logic        cs_q;
   logic [26:0] req_addr_q, req_addr_d;
   logic [7:0]  data_out_q, data_out_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        timeout_err_q, timeout_err_d;

   logic        cs_rise;
   logic        tmo;
   logic        buf_hit;
   logic [7:0]  buf_byte;
   logic        buf_load;

   assign cs_rise = ram_cs && !cs_q;
   assign tmo     = (cnt_q == TMO_CNT);

   resp_hit_buf u_hit_buf (
      .clk         (clk),
      .reset       (reset),
      .load        (buf_load),
      .load_addr   (req_addr_q[26:1]),
      .load_word   (mem_data),
      .invalidate  (invalidate),
      .cmp_addr    (ram_addr[26:1]),
      .cmp_byte_hi (ram_addr[0]),
      .hit         (buf_hit),
      .hit_byte    (buf_byte)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         cs_q          <= 1'b0;
         req_addr_q    <= '0;
         data_out_q    <= KANJI_FILL_BYTE;
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cs_q          <= ram_cs;
         req_addr_q    <= req_addr_d;
         data_out_q    <= data_out_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // An aborted CPU cycle (ram_cs already low) skips DONE on completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_rise) state_d = buf_hit ? DONE : REQ;
         REQ:     if (mem_ack || tmo) state_d = ram_cs ? DONE : IDLE;
         DONE:    if (!ram_cs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_addr_d    = req_addr_q;
      data_out_d    = data_out_q;
      cnt_d         = '0;
      timeout_err_d = timeout_err_q;
      buf_load      = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_rise) begin
               req_addr_d = ram_addr;
               if (buf_hit) data_out_d = buf_byte;
            end
         end
         REQ: begin
            if (mem_ack) begin
               buf_load   = 1'b1;
               data_out_d = sel_byte(mem_data, req_addr_q[0]);
            end else if (tmo) begin
               data_out_d    = KANJI_FILL_BYTE;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   // wait_n drops combinationally on a missing edge so the CPU stalls in that same cycle.
   always_comb begin
      mem_req     = (state_q == REQ);
      mem_addr    = req_addr_q[26:1];
      data_out    = data_out_q;
      timeout_err = timeout_err_q;
      wait_n      = !(reset && (((state_q == IDLE) && cs_rise && !buf_hit) ||
                                (state_q == REQ)));
   end

endmodule
